// File: rtl/ex_pkg.sv
// Shared types and constants for the RV64 execute stage.
// Holds the EX/MA register layout, ALU op bit positions and the forwarding helper.
package ex_pkg;

  localparam int XLEN        = 64;
  localparam int SHAMT_W     = 6;
  localparam int NUM_ALU_OPS = 9;

  // Bit positions inside the one-hot alu_ops bundle, listed in priority order.
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_XOR = 4;
  localparam int OP_SLL = 5;
  localparam int OP_SRL = 6;
  localparam int OP_SRA = 7;
  localparam int OP_SLT = 8;

  // Bit positions inside the io_ops bundle.
  localparam int IO_LOAD  = 0;
  localparam int IO_STORE = 1;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] link;
    logic [4:0]      rd;
    logic [XLEN-1:0] out;
    logic [XLEN-1:0] sdata;
    logic            load;
    logic            store;
  } ex_ma_t;

  localparam ex_ma_t EX_BUBBLE = '0;

  // x0 always reads zero; the younger MA result beats the older WB result.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [4:0]      src,
    input logic [4:0]      ma_rd,
    input logic [XLEN-1:0] ma_out,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_out,
    input logic [XLEN-1:0] rf_val
  );
    logic [XLEN-1:0] val;
    val = rf_val;
    if (src == 5'd0)        val = '0;
    else if (src == ma_rd)  val = ma_out;
    else if (src == wb_rd)  val = wb_out;
    return val;
  endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational integer ALU for the execute stage.
// Several asserted ops resolve by fixed priority; no op passes operand B through.
module ex_alu
  import ex_pkg::*;
(
  input  logic [NUM_ALU_OPS-1:0] op_i,
  input  logic [XLEN-1:0]        a_i,
  input  logic [XLEN-1:0]        b_i,
  output logic [XLEN-1:0]        result_o
);

  logic [SHAMT_W-1:0] shamt;
  logic               lt;

  assign shamt = b_i[SHAMT_W-1:0];
  assign lt    = $signed(a_i) < $signed(b_i);

  always_comb begin
    result_o = b_i;
    if (op_i[OP_ADD])      result_o = a_i + b_i;
    else if (op_i[OP_SUB]) result_o = a_i - b_i;
    else if (op_i[OP_AND]) result_o = a_i & b_i;
    else if (op_i[OP_OR])  result_o = a_i | b_i;
    else if (op_i[OP_XOR]) result_o = a_i ^ b_i;
    else if (op_i[OP_SLL]) result_o = a_i << shamt;
    else if (op_i[OP_SRL]) result_o = a_i >> shamt;
    else if (op_i[OP_SRA]) result_o = $signed(a_i) >>> shamt;
    else if (op_i[OP_SLT]) result_o = {{(XLEN-1){1'b0}}, lt};
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU / address generation, load-use detection
// and the EX/MA pipeline register.
module ex_stage
  import ex_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_ALU_OPS-1:0] alu_ops,
  input  logic [1:0]             io_ops,
  input  logic                   clear,
  input  logic                   stall,
  input  logic                   compressed,
  input  logic [XLEN-1:0]        pc,
  input  logic [4:0]             rd,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  input  logic [XLEN-1:0]        data1,
  input  logic [XLEN-1:0]        data2,
  input  logic [XLEN-1:0]        imm,
  input  logic                   with_imm,
  input  logic [4:0]             ma_rd,
  input  logic [XLEN-1:0]        ma_out,
  input  logic [4:0]             wb_rd,
  input  logic [XLEN-1:0]        wb_out,
  output logic                   ex_valid,
  output logic [XLEN-1:0]        ex_pc,
  output logic [XLEN-1:0]        ex_link,
  output logic [4:0]             ex_rd,
  output logic [XLEN-1:0]        ex_out,
  output logic [XLEN-1:0]        ex_sdata,
  output logic                   ex_load,
  output logic                   ex_store,
  output logic                   hazard_stall
);

  ex_ma_t          ex_q, ex_d, ex_new, ex_rst;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2, op_b, alu_res, mem_addr;
  logic            mem_op;

  assign fwd_rs1  = fwd_sel(rs1, ma_rd, ma_out, wb_rd, wb_out, data1);
  assign fwd_rs2  = fwd_sel(rs2, ma_rd, ma_out, wb_rd, wb_out, data2);
  assign op_b     = with_imm ? imm : fwd_rs2;
  assign mem_addr = fwd_rs1 + imm;
  assign mem_op   = |io_ops;

  ex_alu u_alu (
    .op_i     (alu_ops),
    .a_i      (fwd_rs1),
    .b_i      (op_b),
    .result_o (alu_res)
  );

  // A load in EX/MA cannot feed the instruction in decode this cycle; the
  // bubble it forces clears ex_load, so the request drops after one cycle.
  assign hazard_stall = ~rst & ex_q.valid & ex_q.load & (ex_q.rd != 5'd0) &
                        ((ex_q.rd == rs1) | ((ex_q.rd == rs2) & ~with_imm));

  // Update order: clear or hazard inserts a bubble, stall holds, else capture.
  // A flush arriving during a stall still wins so it is never lost.
  always_comb begin
    ex_new       = EX_BUBBLE;
    ex_new.valid = 1'b1;
    ex_new.pc    = pc;
    ex_new.link  = pc + (compressed ? 64'd2 : 64'd4);
    ex_new.rd    = rd;
    ex_new.out   = mem_op ? mem_addr : alu_res;
    ex_new.sdata = fwd_rs2;
    ex_new.store = io_ops[IO_STORE];
    ex_new.load  = io_ops[IO_LOAD] & ~io_ops[IO_STORE];

    ex_rst    = EX_BUBBLE;
    ex_rst.pc = RESET_PC;

    ex_d = ex_q;
    if (clear || hazard_stall) ex_d = EX_BUBBLE;
    else if (!stall)           ex_d = ex_new;
  end

  always_ff @(posedge clk) begin
    if (rst) ex_q <= ex_rst;
    else     ex_q <= ex_d;
  end

  assign ex_valid = ex_q.valid;
  assign ex_pc    = ex_q.pc;
  assign ex_link  = ex_q.link;
  assign ex_rd    = ex_q.rd;
  assign ex_out   = ex_q.out;
  assign ex_sdata = ex_q.sdata;
  assign ex_load  = ex_q.load;
  assign ex_store = ex_q.store;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases with literal expectations, then random
// traffic checked every cycle against a behavioural model of the stage.
module tb_ex_stage;

  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        rst, clear, stall, compressed, with_imm;
  logic [8:0]  alu_ops;
  logic [1:0]  io_ops;
  logic [63:0] pc, data1, data2, imm, ma_out, wb_out;
  logic [4:0]  rd, rs1, rs2, ma_rd, wb_rd;
  logic        ex_valid, ex_load, ex_store, hazard_stall;
  logic [63:0] ex_pc, ex_link, ex_out, ex_sdata;
  logic [4:0]  ex_rd;

  int total = 0;
  int bad   = 0;

  ex_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .alu_ops(alu_ops), .io_ops(io_ops),
    .clear(clear), .stall(stall), .compressed(compressed), .pc(pc),
    .rd(rd), .rs1(rs1), .rs2(rs2), .data1(data1), .data2(data2),
    .imm(imm), .with_imm(with_imm), .ma_rd(ma_rd), .ma_out(ma_out),
    .wb_rd(wb_rd), .wb_out(wb_out), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_link(ex_link), .ex_rd(ex_rd), .ex_out(ex_out), .ex_sdata(ex_sdata),
    .ex_load(ex_load), .ex_store(ex_store), .hazard_stall(hazard_stall)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_init = 1'b0;
  logic        m_care;          // pc/link/out/sdata are defined (not a bubble)
  logic        m_valid, m_load, m_store;
  logic [4:0]  m_rd;
  logic [63:0] m_pc, m_link, m_out, m_sdata;

  function automatic logic [63:0] m_fwd(input logic [4:0] s, input logic [63:0] rf);
    if (s == 0)     return 64'd0;
    if (s == ma_rd) return ma_out;
    if (s == wb_rd) return wb_out;
    return rf;
  endfunction

  function automatic logic [63:0] m_alu(input logic [8:0] ops, input logic [63:0] a,
                                        input logic [63:0] b);
    int first;
    first = -1;
    for (int i = 8; i >= 0; i--) if (ops[i]) first = i;
    case (first)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << b[5:0];
      6: return a >> b[5:0];
      7: return $signed(a) >>> b[5:0];
      8: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      default: return b;
    endcase
  endfunction

  function automatic logic m_hazard();
    return !rst && m_valid && m_load && m_rd != 0 &&
           (m_rd == rs1 || (m_rd == rs2 && !with_imm));
  endfunction

  always @(posedge clk) begin
    logic [63:0] a, b;
    logic        hz;
    hz = m_hazard();
    a  = m_fwd(rs1, data1);
    b  = with_imm ? imm : m_fwd(rs2, data2);
    if (rst) begin
      m_init = 1'b1; m_care = 1'b1; m_valid = 0; m_load = 0; m_store = 0; m_rd = 0;
      m_pc = RESET_PC; m_link = 0; m_out = 0; m_sdata = 0;
    end else if (clear || hz) begin
      m_care = 1'b0; m_valid = 0; m_load = 0; m_store = 0; m_rd = 0;
    end else if (!stall) begin
      m_care  = 1'b1;
      m_valid = 1'b1;
      m_pc    = pc;
      m_link  = compressed ? pc + 2 : pc + 4;
      m_rd    = rd;
      m_store = io_ops[1];
      m_load  = io_ops[0] && !io_ops[1];
      m_out   = (io_ops != 0) ? a + imm : m_alu(alu_ops, a, b);
      m_sdata = m_fwd(rs2, data2);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_init) begin
      chk("hazard_stall", hazard_stall, m_hazard());
      chk("ex_valid", ex_valid, m_valid);
      chk("ex_rd", ex_rd, m_rd);
      chk("ex_load", ex_load, m_load);
      chk("ex_store", ex_store, m_store);
      if (m_care) begin
        chk("ex_pc", ex_pc, m_pc);
        chk("ex_link", ex_link, m_link);
        chk("ex_out", ex_out, m_out);
        chk("ex_sdata", ex_sdata, m_sdata);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    rst = 0; clear = 0; stall = 0; compressed = 0; with_imm = 0;
    alu_ops = 0; io_ops = 0; pc = 0; rd = 0; rs1 = 0; rs2 = 0;
    data1 = 0; data2 = 0; imm = 0; ma_rd = 0; ma_out = 0; wb_rd = 0; wb_out = 0;
  endtask

  task automatic drive_random();
    int mode;
    rst        = ($urandom_range(0, 63) == 0);
    clear      = ($urandom_range(0, 9) == 0);
    stall      = ($urandom_range(0, 5) == 0);
    compressed = $urandom_range(0, 1) == 1;
    with_imm   = $urandom_range(0, 1) == 1;
    mode = $urandom_range(0, 3);
    if (mode < 2)       alu_ops = 9'd1 << $urandom_range(0, 8);
    else if (mode == 2) alu_ops = 9'($urandom);
    else                alu_ops = 0;
    io_ops = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
    pc     = {$urandom, $urandom};
    rd     = 5'($urandom_range(0, 7));
    rs1    = 5'($urandom_range(0, 7));
    rs2    = 5'($urandom_range(0, 7));
    ma_rd  = 5'($urandom_range(0, 7));
    wb_rd  = 5'($urandom_range(0, 7));
    data1  = {$urandom, $urandom};
    data2  = {$urandom, $urandom};
    imm    = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
    ma_out = {$urandom, $urandom};
    wb_out = {$urandom, $urandom};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("reset_pc", ex_pc, RESET_PC);
    chk("reset_valid", ex_valid, 0);
    chk("reset_out", ex_out, 0);

    // MA forward on rs1 into an add
    idle();
    rs1 = 3; rs2 = 4; data1 = 256; data2 = 512; ma_rd = 3; ma_out = 64'hDDAA;
    alu_ops = 9'd1; rd = 5; imm = 1024;
    tick();
    chk("add_fwd_out", ex_out, 64'hDFAA);
    chk("add_fwd_rd", ex_rd, 5);
    chk("add_fwd_valid", ex_valid, 1);

    // load+store together: store wins, address uses imm
    io_ops = 2'b11;
    tick();
    chk("ldst_store", ex_store, 1);
    chk("ldst_load", ex_load, 0);
    chk("ldst_addr", ex_out, 64'hE1AA);
    chk("ldst_sdata", ex_sdata, 512);

    // forwarding priority MA > WB > zero register
    idle();
    alu_ops = 9'd1; with_imm = 1; rs1 = 6; rd = 1;
    ma_rd = 6; ma_out = 1; wb_rd = 6; wb_out = 2;
    tick();
    chk("fwd_ma", ex_out, 1);
    ma_rd = 0;
    tick();
    chk("fwd_wb", ex_out, 2);
    rs1 = 0;
    tick();
    chk("fwd_x0", ex_out, 0);

    // load-use hazard
    idle();
    io_ops = 2'b01; rd = 5; imm = 64'h100;
    tick();
    chk("lu_load", ex_load, 1);
    idle();
    alu_ops = 9'd1; rs1 = 5; rd = 7;
    #1;
    chk("lu_hazard_on", hazard_stall, 1);
    tick();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_rd", ex_rd, 0);
    chk("lu_hazard_off", hazard_stall, 0);
    tick();
    chk("lu_issue_valid", ex_valid, 1);
    chk("lu_issue_rd", ex_rd, 7);

    // stall holds, clear during stall bubbles
    idle();
    alu_ops = 9'd1; with_imm = 1; imm = 64'h1234; rd = 9;
    tick();
    stall = 1; rd = 10; imm = 5;
    repeat (3) begin
      tick();
      chk("stall_out", ex_out, 64'h1234);
      chk("stall_rd", ex_rd, 9);
    end
    clear = 1;
    tick();
    chk("clear_valid", ex_valid, 0);
    chk("clear_rd", ex_rd, 0);

    // sra, slt, compressed link, reset mid-stream
    idle();
    alu_ops = 9'd1 << 7; rs1 = 1; data1 = 64'h8000_0000_0000_0000;
    with_imm = 1; imm = 63; rd = 2;
    tick();
    chk("sra_out", ex_out, 64'hFFFF_FFFF_FFFF_FFFF);
    alu_ops = 9'd1 << 8; data1 = 64'hFFFF_FFFF_FFFF_FFFF; imm = 1;
    tick();
    chk("slt_out", ex_out, 1);
    compressed = 1; pc = 64'h400;
    tick();
    chk("c_link", ex_link, 64'h402);
    rst = 1;
    tick();
    chk("rst2_valid", ex_valid, 0);
    chk("rst2_pc", ex_pc, RESET_PC);
    chk("rst2_out", ex_out, 0);
    chk("rst2_rd", ex_rd, 0);

    // random traffic, checked by the compare process
    repeat (3000) begin
      drive_random();
      tick();
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
